mem_rw_bank: RTL

Parametrised, synthesizable successor to the DPI-C RAM helper. Provides a flow-controlled word-addressed memory with one read channel (request/response handshake, buffered responses) and one fire-and-forget write channel with bitwise mask. It serves as the in-fabric main-memory backend when DPI-C is unavailable (synthesis, emulation). It adds read backpressure, write-first collision handling, out-of-range detection and an error counter.

---
 rtl/mem_rw_bank.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mem_rw_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_rw_bank
// Purpose  : Flow-controlled, word-addressed memory bank. One read channel with
//            a request/response handshake and a buffered response FIFO, and one
//            fire-and-forget write channel with a bitwise write mask.
//            Out-of-range accesses are flagged and counted.
// Ports    : clock, reset           - sole clock (rising edge), sync active-high reset
//            r_req_valid/ready/index - read request handshake and word index
//            r_resp_valid/ready      - read response handshake (FIFO head)
//            r_resp_data/err         - head data / out-of-range flag (0 when idle)
//            w_valid/index/data/mask - write strobe, index, data, bit-enable mask
//            w_err                   - pulse: previous-cycle write was out of range
//            err_cnt                 - saturating count of out-of-range accesses
// Revision : 1.0 - initial release
// ============================================================================
module mem_rw_bank #(
    parameter int DATA_W     = 64,
    parameter int INDEX_W    = 64,
    parameter int DEPTH_LOG2 = 16,
    parameter int RESP_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               r_req_valid,
    output logic               r_req_ready,
    input  logic [INDEX_W-1:0] r_req_index,
    output logic               r_resp_valid,
    input  logic               r_resp_ready,
    output logic [DATA_W-1:0]  r_resp_data,
    output logic               r_resp_err,
    input  logic               w_valid,
    input  logic [INDEX_W-1:0] w_index,
    input  logic [DATA_W-1:0]  w_data,
    input  logic [DATA_W-1:0]  w_mask,
    output logic               w_err,
    output logic [15:0]        err_cnt
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_AW    = $clog2(RESP_DEPTH);
    localparam int c_PW    = c_AW + 1;
    localparam logic [c_PW:0] c_CREDITS = (c_PW + 1)'(RESP_DEPTH);

    // ------------------------------------------------------------------
    // Storage and write path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [DEPTH_LOG2-1:0] w_wr_addr;
    logic                  w_wr_oor;
    logic                  w_wr_en;
    logic [DATA_W-1:0]     w_wr_merged;

    assign w_wr_addr   = w_index[DEPTH_LOG2-1:0];
    assign w_wr_oor    = |w_index[INDEX_W-1:DEPTH_LOG2];
    assign w_wr_en     = w_valid && !reset && !w_wr_oor;
    assign w_wr_merged = (r_mem[w_wr_addr] & ~w_mask) | (w_data & w_mask);

    // Array has no reset: contents survive reset and are undefined at power-up.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_merged;
        end
    end

    // ------------------------------------------------------------------
    // Read stage s1
    // ------------------------------------------------------------------
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic                  w_rd_oor;
    logic                  w_rd_fire;
    logic                  w_rd_hit;
    logic [DATA_W-1:0]     w_rd_word;

    logic                  r_s1_valid;
    logic [DATA_W-1:0]     r_s1_data;
    logic                  r_s1_err;

    assign w_rd_addr = r_req_index[DEPTH_LOG2-1:0];
    assign w_rd_oor  = |r_req_index[INDEX_W-1:DEPTH_LOG2];
    assign w_rd_fire = r_req_valid && r_req_ready;
    // Same-edge write to the same in-range word: forward the merged value so the
    // read observes the write (write-first).
    assign w_rd_hit  = w_wr_en && !w_rd_oor && (w_wr_addr == w_rd_addr);
    assign w_rd_word = w_rd_oor ? '0 : (w_rd_hit ? w_wr_merged : r_mem[w_rd_addr]);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_fire;
        end
    end

    always_ff @(posedge clock) begin
        if (w_rd_fire) begin
            r_s1_data <= w_rd_word;
            r_s1_err  <= w_rd_oor;
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_fifo_data [RESP_DEPTH];
    logic              r_fifo_err  [RESP_DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   w_count;
    logic              w_push;
    logic              w_pop;
    logic [c_PW:0]     w_credits_used;

    assign w_count = r_wr_ptr - r_rd_ptr;
    // Credit accounting reserves a slot for s1, so a push can never overflow.
    assign w_push  = r_s1_valid;
    assign w_pop   = r_resp_valid && r_resp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_fifo_data[r_wr_ptr[c_AW-1:0]] <= r_s1_data;
            r_fifo_err[r_wr_ptr[c_AW-1:0]]  <= r_s1_err;
        end
    end

    // Pops in the current cycle deliberately do not add credit, keeping
    // r_req_ready a function of registered state only (plus reset gating).
    assign w_credits_used = {1'b0, w_count} + (c_PW + 1)'(r_s1_valid);
    assign r_req_ready    = !reset && (w_credits_used < c_CREDITS);
    assign r_resp_valid   = (w_count != '0);
    assign r_resp_data    = r_resp_valid ? r_fifo_data[r_rd_ptr[c_AW-1:0]] : '0;
    assign r_resp_err     = r_resp_valid ? r_fifo_err[r_rd_ptr[c_AW-1:0]]  : 1'b0;

    // ------------------------------------------------------------------
    // Error reporting
    // ------------------------------------------------------------------
    logic        r_wr_err;
    logic [15:0] r_err_cnt;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, w_rd_fire && w_rd_oor} + {1'b0, w_valid && w_wr_oor};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'b0, w_err_inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_err  <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_wr_err  <= w_valid && w_wr_oor;
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign w_err   = r_wr_err;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire
